// File: rtl/ram_boot_sched.sv
// rtl/ram_boot_sched.sv - RAM ownership sequencer for boot load, core run and debug halt
//
// Purpose: owns the single-port program/stack RAM. After reset it streams a
// program image from the loader port, then hands the RAM to the core. While
// the core is halted, the debug port owns the RAM until resume.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ld_valid/ld_data/ld_last      loader word stream; ld_ready accepts it
//   core_addr/core_we/core_wdata  core RAM access; core_rdata read data back
//   hlt                           halt request level from the decoder
//   core_run                      core clock-enable
//   dbg_valid/dbg_we/dbg_addr/dbg_wdata  one-cycle debug access (HALT only)
//   dbg_rvalid/dbg_rdata          registered debug read response
//   dbg_resume                    return from HALT to RUN
//   ram_addr/ram_we/ram_wdata     RAM access, muxed by state
//   ram_rdata                     RAM combinational read data
//   state                         00 LOAD, 01 RUN, 10 HALT
//   ld_count                      number of words loaded so far
module ram_boot_sched #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 3,
    parameter int LOAD_LEN = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              hlt,
    output logic              core_run,
    input  logic              dbg_valid,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_resume,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   ld_count
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'b00,
        S_RUN    = 2'b01,
        S_HALT   = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_LEN - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     ld_count_q;
    logic                dbg_rvalid_q;
    logic [DATA_W-1:0]   dbg_rdata_q;

    // The unused encoding is treated as HALT everywhere, so decode HALT from bit 1.
    logic is_load;
    logic is_run;
    logic is_halt;
    logic ld_accept;
    logic dbg_read;

    assign is_load   = (state_q == S_LOAD);
    assign is_run    = (state_q == S_RUN);
    assign is_halt   = state_q[1];
    assign ld_accept = is_load && ld_valid;
    assign dbg_read  = is_halt && dbg_valid && !dbg_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (ld_accept && (ld_last || (ld_count_q == LAST_IDX))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (hlt) begin
                    state_d = S_HALT;
                end
            end
            default: begin
                if (dbg_resume) begin
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            ld_count_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_read;
            if (ld_accept) begin
                ld_count_q <= ld_count_q + (ADDR_W+1)'(1);
            end
            if (dbg_read) begin
                dbg_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM port mux; the core access in the cycle hlt is sampled still goes through.
    always_comb begin
        ram_addr  = ld_count_q[ADDR_W-1:0];
        ram_we    = ld_valid;
        ram_wdata = ld_data;
        if (is_run) begin
            ram_addr  = core_addr;
            ram_we    = core_we;
            ram_wdata = core_wdata;
        end else if (is_halt) begin
            ram_addr  = dbg_addr;
            ram_we    = dbg_valid && dbg_we;
            ram_wdata = dbg_wdata;
        end
    end

    assign core_rdata = ram_rdata;
    assign ld_ready   = is_load;
    assign core_run   = is_run;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign state      = state_q;
    assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_ram_boot_sched.sv
// tb/tb_ram_boot_sched.sv - self-checking bench for ram_boot_sched
module tb_ram_boot_sched;

    localparam int AW = 12;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- instance A: LOAD_LEN = 4096 ----------------
    logic          a_ld_valid = 0, a_ld_last = 0, a_ld_ready;
    logic [DW-1:0] a_ld_data = 0;
    logic [AW-1:0] a_core_addr = 0;
    logic          a_core_we = 0;
    logic [DW-1:0] a_core_wdata = 0, a_core_rdata;
    logic          a_hlt = 0, a_core_run;
    logic          a_dbg_valid = 0, a_dbg_we = 0, a_dbg_rvalid, a_dbg_resume = 0;
    logic [AW-1:0] a_dbg_addr = 0;
    logic [DW-1:0] a_dbg_wdata = 0, a_dbg_rdata;
    logic [AW-1:0] a_ram_addr;
    logic          a_ram_we;
    logic [DW-1:0] a_ram_wdata, a_ram_rdata;
    logic [1:0]    a_state;
    logic [AW:0]   a_ld_count;
    logic [DW-1:0] mem_a [0:(1<<AW)-1];

    ram_boot_sched #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(4096)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_last(a_ld_last), .ld_ready(a_ld_ready),
        .core_addr(a_core_addr), .core_we(a_core_we), .core_wdata(a_core_wdata), .core_rdata(a_core_rdata),
        .hlt(a_hlt), .core_run(a_core_run),
        .dbg_valid(a_dbg_valid), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
        .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata), .dbg_resume(a_dbg_resume),
        .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .state(a_state), .ld_count(a_ld_count)
    );

    assign a_ram_rdata = mem_a[a_ram_addr];
    always @(posedge clk) if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;

    // ---------------- instance B: LOAD_LEN = 8 ----------------
    logic          b_ld_valid = 0, b_ld_last = 0, b_ld_ready;
    logic [DW-1:0] b_ld_data = 0;
    logic [AW-1:0] b_core_addr = 0;
    logic          b_core_we = 0;
    logic [DW-1:0] b_core_wdata = 0, b_core_rdata;
    logic          b_hlt = 0, b_core_run;
    logic          b_dbg_valid = 0, b_dbg_we = 0, b_dbg_rvalid, b_dbg_resume = 0;
    logic [AW-1:0] b_dbg_addr = 0;
    logic [DW-1:0] b_dbg_wdata = 0, b_dbg_rdata;
    logic [AW-1:0] b_ram_addr;
    logic          b_ram_we;
    logic [DW-1:0] b_ram_wdata, b_ram_rdata;
    logic [1:0]    b_state;
    logic [AW:0]   b_ld_count;
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    ram_boot_sched #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
        .core_addr(b_core_addr), .core_we(b_core_we), .core_wdata(b_core_wdata), .core_rdata(b_core_rdata),
        .hlt(b_hlt), .core_run(b_core_run),
        .dbg_valid(b_dbg_valid), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata), .dbg_resume(b_dbg_resume),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .state(b_state), .ld_count(b_ld_count)
    );

    assign b_ram_rdata = mem_b[b_ram_addr];
    always @(posedge clk) if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Debug read scoreboard: every response must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n && a_dbg_rvalid) begin
            if (exp_q.size() == 0) check("dbg_rvalid_unexpected", 32'(a_dbg_rvalid), 32'd0);
            else check("dbg_rdata_sb", 32'(a_dbg_rdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        // Reset values
        #12;
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_core_run", 32'(a_core_run), 32'd0);
        check("rst_ld_ready", 32'(a_ld_ready), 32'd1);
        check("rst_ld_count", 32'(a_ld_count), 32'd0);
        check("rst_dbg_rvalid", 32'(a_dbg_rvalid), 32'd0);
        check("rst_dbg_rdata", 32'(a_dbg_rdata), 32'd0);
        check("rst_ram_addr", 32'(a_ram_addr), 32'd0);
        check("rst_ram_we0", 32'(a_ram_we), 32'd0);
        a_ld_valid = 1'b1;
        #1 check("rst_ram_we1", 32'(a_ram_we), 32'd1);
        a_ld_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Load 1..5 with ld_last on word 5
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                check("load_state_before_last", 32'(a_state), 32'd0);
                check("load_count4", 32'(a_ld_count), 32'd4);
            end
            a_ld_valid = 1'b1;
            a_ld_data  = DW'(i);
            a_ld_last  = (i == 5);
            step();
        end
        a_ld_valid = 1'b0;
        a_ld_last  = 1'b0;
        check("load_state_run", 32'(a_state), 32'd1);
        check("load_core_run", 32'(a_core_run), 32'd1);
        check("load_ld_ready", 32'(a_ld_ready), 32'd0);
        check("load_count5", 32'(a_ld_count), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("load_mem%0d", i), 32'(mem_a[i]), 32'(i + 1));

        // Core write in the same cycle as hlt
        a_core_addr = 12'hABC; a_core_we = 1'b1; a_core_wdata = 3'd3; a_hlt = 1'b1;
        step();
        a_core_we = 1'b0; a_hlt = 1'b0;
        check("core_wr_mem", 32'(mem_a[12'hABC]), 32'd3);
        check("halt_state", 32'(a_state), 32'd2);
        check("halt_core_run", 32'(a_core_run), 32'd0);
        check("core_rdata", 32'(a_core_rdata), 32'(mem_a[a_ram_addr]));

        // Debug write then read
        a_dbg_valid = 1'b1; a_dbg_we = 1'b1; a_dbg_addr = 12'h010; a_dbg_wdata = 3'd6;
        step();
        check("dbg_wr_mem", 32'(mem_a[12'h010]), 32'd6);
        a_dbg_we = 1'b0;
        exp_q.push_back(3'd6);
        step();
        a_dbg_valid = 1'b0;
        check("dbg_rvalid_pulse", 32'(a_dbg_rvalid), 32'd1);
        check("dbg_rdata", 32'(a_dbg_rdata), 32'd6);
        step();
        check("dbg_rvalid_drop", 32'(a_dbg_rvalid), 32'd0);

        // Debug write together with resume: write lands, then RUN
        a_dbg_valid = 1'b1; a_dbg_we = 1'b1; a_dbg_addr = 12'h020; a_dbg_wdata = 3'd5; a_dbg_resume = 1'b1;
        step();
        a_dbg_valid = 1'b0; a_dbg_resume = 1'b0;
        check("resume_wr_mem", 32'(mem_a[12'h020]), 32'd5);
        check("resume_state", 32'(a_state), 32'd1);
        check("resume_core_run", 32'(a_core_run), 32'd1);

        // Debug access during RUN is ignored
        a_dbg_valid = 1'b1; a_dbg_we = 1'b1; a_dbg_addr = 12'h030; a_dbg_wdata = 3'd4;
        step();
        check("run_dbg_no_write", 32'(mem_a[12'h030]), 32'd0);
        a_dbg_we = 1'b0;
        step();
        a_dbg_valid = 1'b0;
        check("run_dbg_no_rvalid", 32'(a_dbg_rvalid), 32'd0);

        // hlt held through a resume re-enters HALT
        a_hlt = 1'b1;
        step();
        check("hlt_held_halt", 32'(a_state), 32'd2);
        a_dbg_resume = 1'b1;
        step();
        a_dbg_resume = 1'b0;
        check("hlt_held_resume", 32'(a_state), 32'd1);
        step();
        check("hlt_held_rehalt", 32'(a_state), 32'd2);
        a_hlt = 1'b0;

        // Asynchronous reset during HALT
        #2 rst_n = 1'b0;
        #1;
        check("arst_halt_state", 32'(a_state), 32'd0);
        check("arst_halt_core_run", 32'(a_core_run), 32'd0);
        check("arst_halt_ld_count", 32'(a_ld_count), 32'd0);
        check("arst_halt_rvalid", 32'(a_dbg_rvalid), 32'd0);
        step();
        rst_n = 1'b1;

        // Partial load of three words, then asynchronous reset
        for (int i = 0; i < 3; i++) begin
            a_ld_valid = 1'b1; a_ld_data = 3'd2;
            step();
        end
        a_ld_valid = 1'b0;
        check("partial_count3", 32'(a_ld_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_load_state", 32'(a_state), 32'd0);
        check("arst_load_count", 32'(a_ld_count), 32'd0);
        check("arst_load_core_run", 32'(a_core_run), 32'd0);
        step();
        rst_n = 1'b1;
        a_ld_valid = 1'b1; a_ld_data = 3'd5;
        step();
        a_ld_data = 3'd6; a_ld_last = 1'b1;
        step();
        a_ld_valid = 1'b0; a_ld_last = 1'b0;
        check("reload_mem0", 32'(mem_a[0]), 32'd5);
        check("reload_mem1", 32'(mem_a[1]), 32'd6);
        check("reload_mem2", 32'(mem_a[2]), 32'd2);
        check("reload_count", 32'(a_ld_count), 32'd2);
        check("reload_state", 32'(a_state), 32'd1);

        // Instance B (reset above also restarted it): 8 words with valid toggling
        check("b_start_state", 32'(b_state), 32'd0);
        for (int k = 0; k < 8; k++) begin
            b_ld_valid = 1'b1; b_ld_data = 3'd7;
            step();
            if (k == 6) check("b_state_after7", 32'(b_state), 32'd0);
            if (k == 7) begin
                check("b_state_after8", 32'(b_state), 32'd1);
                check("b_core_run_after8", 32'(b_core_run), 32'd1);
            end
            b_ld_valid = 1'b0;
            if (k < 7) step();
        end
        b_ld_valid = 1'b1; b_ld_data = 3'd3;
        step();
        b_ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("b_mem%0d", i), 32'(mem_b[i]), 32'd7);
        check("b_mem8_unwritten", 32'(mem_b[8]), 32'd0);
        check("b_ld_count", 32'(b_ld_count), 32'd8);
        check("b_no_rvalid", 32'(b_dbg_rvalid), 32'd0);

        step();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
